// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle between a binary source and the BCD converter
interface bin2bcd_seq_if;
  logic        start;
  logic [9:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        ovf;
  modport master (output start, bin_in, input busy, done, bcd_out, ovf);
  modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 10-bit binary to 3-digit BCD, one double-dabble iteration per clock, saturating at 999
module bin2bcd_seq (
  input  logic          sys_clk,
  input  logic          sys_rst,
  bin2bcd_seq_if.slave  b
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [9:0]  sr;
  logic [11:0] scr;
  logic        ovf_i;
  logic [11:0] adj;
  // per-digit +3 correction; each sum is 4 bits wide so no carry crosses digits
  assign adj = {scr[11:8] + (scr[11:8] >= 4'd5 ? 4'd3 : 4'd0),
                scr[7:4]  + (scr[7:4]  >= 4'd5 ? 4'd3 : 4'd0),
                scr[3:0]  + (scr[3:0]  >= 4'd5 ? 4'd3 : 4'd0)};
  assign b.busy = state == SHIFT;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      scr       <= '0;
      ovf_i     <= 1'b0;
      b.done    <= 1'b0;
      b.bcd_out <= '0;
      b.ovf     <= 1'b0;
    end else begin
      b.done <= 1'b0;
      if (state == IDLE) begin
        if (b.start) begin
          sr    <= b.bin_in > 10'd999 ? 10'd999 : b.bin_in;
          ovf_i <= b.bin_in > 10'd999;
          scr   <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
      end else begin
        scr <= {adj[10:0], sr[9]};
        sr  <= {sr[8:0], 1'b0};
        cnt <= cnt + 4'd1;
        if (cnt == 4'd9) begin
          b.bcd_out <= {adj[10:0], sr[9]};
          b.ovf     <= ovf_i;
          b.done    <= 1'b1;
          state     <= IDLE;
        end
      end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: vector table plus corner sequences, results checked through an expected-result queue
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst;
  bin2bcd_seq_if bif ();
  bin2bcd_seq dut (.sys_clk(clk), .sys_rst(rst), .b(bif));
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  bin;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t        tbl [10];
  logic [12:0] exp_q [$];
  logic [11:0] hold_bcd = '0;
  logic        hold_ovf = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          lat;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every done pops one expectation; outputs must hold otherwise
  always @(negedge clk) begin
    if (rst) begin
      hold_bcd = '0;
      hold_ovf = 1'b0;
      check("rst_done", int'(bif.done), 0);
      check("rst_busy", int'(bif.busy), 0);
    end else if (bif.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done bcd %0h at %0t", bif.bcd_out, $time);
      end else begin
        {hold_bcd, hold_ovf} = exp_q.pop_front();
      end
    end
    check("bcd_out", int'(bif.bcd_out), int'(hold_bcd));
    check("ovf", int'(bif.ovf), int'(hold_ovf));
  end

  task automatic start_conv(input logic [9:0] bin, input logic [11:0] e_bcd, input logic e_ovf, input bit push);
    bif.start  = 1'b1;
    bif.bin_in = bin;
    if (push) exp_q.push_back({e_bcd, e_ovf});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) bif.start = 1'b0;
      if (bif.done) begin
        check("busy_in_done", int'(bif.busy), 0);
        break;
      end
      check("busy_during", int'(bif.busy), 1);
      if (n >= 30) begin
        checks++;
        errors++;
        $display("FAIL done_timeout waited %0d cycles expected 11", n);
        break;
      end
    end
  endtask

  function automatic logic [12:0] model(input int v);
    int c;
    c = v > 999 ? 999 : v;
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10), v > 999};
  endfunction

  initial begin
    tbl[0] = '{10'd573,  12'h573, 1'b0};
    tbl[1] = '{10'd0,    12'h000, 1'b0};
    tbl[2] = '{10'd9,    12'h009, 1'b0};
    tbl[3] = '{10'd10,   12'h010, 1'b0};
    tbl[4] = '{10'd99,   12'h099, 1'b0};
    tbl[5] = '{10'd100,  12'h100, 1'b0};
    tbl[6] = '{10'd999,  12'h999, 1'b0};
    tbl[7] = '{10'd1000, 12'h999, 1'b1};
    tbl[8] = '{10'd1023, 12'h999, 1'b1};
    tbl[9] = '{10'd42,   12'h042, 1'b0};
    rst = 1'b1;
    bif.start  = 1'b0;
    bif.bin_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // start on the very first edge after reset release
    for (int i = 0; i < 10; i++) begin
      start_conv(tbl[i].bin, tbl[i].bcd, tbl[i].ovf, 1'b1);
      wait_done(lat);
      check("latency", lat, 11);
      repeat (2) @(negedge clk);
    end
    // start while busy must be ignored
    start_conv(10'd123, 12'h123, 1'b0, 1'b1);
    @(negedge clk);
    bif.start = 1'b0;
    repeat (4) @(negedge clk);
    start_conv(10'd456, 12'h456, 1'b0, 1'b0);
    wait_done(lat);
    check("latency_ignore", lat, 6);
    repeat (15) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    // back-to-back: new start in the done cycle
    start_conv(10'd700, 12'h700, 1'b0, 1'b1);
    wait_done(lat);
    start_conv(10'd800, 12'h800, 1'b0, 1'b1);
    wait_done(lat);
    check("b2b_latency", lat, 11);
    for (int i = 0; i < 6; i++) begin
      int v;
      logic [12:0] m;
      v = $urandom_range(0, 1023);
      m = model(v);
      @(negedge clk);
      start_conv(10'(v), m[12:1], m[0], 1'b1);
      wait_done(lat);
      check("rand_latency", lat, 11);
    end
    // reset mid-conversion aborts without a result
    @(negedge clk);
    start_conv(10'd321, 12'h321, 1'b0, 1'b1);
    wait_done(lat);
    @(negedge clk);
    start_conv(10'd654, 12'h654, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bif.start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bcd", int'(bif.bcd_out), 0);
    check("async_rst_busy", int'(bif.busy), 0);
    check("async_rst_ovf", int'(bif.ovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("no_done_after_abort", exp_q.size(), 0);
    start_conv(10'd654, 12'h654, 1'b0, 1'b1);
    wait_done(lat);
    check("post_rst_latency", lat, 11);
    repeat (3) @(negedge clk);
    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
